// File: rtl/pwm_pkg.sv
// Shared types and helpers for the multi-channel pulse width meter.
package pwm_pkg;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(n)) r++;
    return r;
  endfunction

  // Channel index width, never below one bit.
  function automatic int unsigned ch_width(input int unsigned n);
    return (n < 2) ? 1 : clog2(n);
  endfunction

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MEAS = 1'b1
  } ch_state_t;

  // Result layout is {sat, lost, width}; width travels alongside since its size is a parameter.
  typedef struct packed {
    logic sat;
    logic lost;
  } res_flags_t;

endpackage

// File: rtl/multi_pulse_width_meter_if.sv
// Result stream from the meter to its consumer.
interface multi_pulse_width_meter_if #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CNT_W  = 16
);
  localparam int unsigned CH_W = pwm_pkg::ch_width(NUM_CH);

  logic              m_valid;
  logic              m_ready;
  logic [CH_W-1:0]   m_ch;
  logic [CNT_W-1:0]  m_width;
  logic              m_sat;
  logic              m_lost;

  modport master (output m_valid, m_ch, m_width, m_sat, m_lost, input m_ready);
  modport slave  (input m_valid, m_ch, m_width, m_sat, m_lost, output m_ready);
endinterface

// File: rtl/pwm_channel.sv
// One measurement channel: synchroniser, polarity, edge detect, width FSM and a
// single-entry holding register.
module pwm_channel
  import pwm_pkg::*;
#(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned ACTIVE_LOW  = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             sig,
  input  logic             pop,
  output logic             hold_v,
  output logic [CNT_W-1:0] hold_width,
  output res_flags_t       hold_flags
);

  localparam logic             INACTIVE = 1'(ACTIVE_LOW);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s_d_q;
  logic                   s_c, lead_c, trail_c;
  ch_state_t              state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   sat_q, sat_d, load_c;

  assign s_c     = sync_q[SYNC_STAGES-1] ^ INACTIVE;
  assign lead_c  = s_c & ~s_d_q;
  assign trail_c = ~s_c & s_d_q;

  // Resetting to the inactive level lets a pin held active through reset produce a lead.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= {SYNC_STAGES{INACTIVE}};
      s_d_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sig};
      s_d_q  <= s_c;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sat_q   <= sat_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sat_d   = sat_q;
    load_c  = 1'b0;
    if (!en) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      sat_d   = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (lead_c) begin
            state_d = ST_MEAS;
            cnt_d   = CNT_W'(1);
            sat_d   = 1'b0;
          end
        end
        ST_MEAS: begin
          if (trail_c) begin
            state_d = ST_IDLE;
            load_c  = 1'b1;
          end else if (s_c) begin
            if (cnt_q == CNT_MAX) sat_d = 1'b1;
            else                  cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // A fresh result overwrites an unread one; it is only "lost" if nobody popped it this cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_v     <= 1'b0;
      hold_width <= '0;
      hold_flags <= '0;
    end else if (load_c) begin
      hold_v          <= 1'b1;
      hold_width      <= cnt_q;
      hold_flags.sat  <= sat_q;
      hold_flags.lost <= hold_v & ~pop;
    end else if (pop) begin
      hold_v <= 1'b0;
    end
  end

endmodule

// File: rtl/multi_pulse_width_meter.sv
// Multi-channel pulse width meter: per-channel measurement, round-robin drain
// into one registered valid/ready result stream.
module multi_pulse_width_meter
  import pwm_pkg::*;
#(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned ACTIVE_LOW  = 0
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      en,
  input  logic [NUM_CH-1:0]         sig_in,
  multi_pulse_width_meter_if.master mif
);

  localparam int unsigned CH_W = ch_width(NUM_CH);

  logic [NUM_CH-1:0] hold_v;
  logic [CNT_W-1:0]  hold_width [NUM_CH];
  res_flags_t        hold_flags [NUM_CH];
  logic [NUM_CH-1:0] pop_c;

  logic [CH_W-1:0]   ptr_q;
  logic [CH_W-1:0]   gnt_c;
  logic              gnt_v_c;
  logic              out_load_c;

  logic              out_v_q;
  logic [CH_W-1:0]   ch_q;
  logic [CNT_W-1:0]  width_q;
  res_flags_t        flags_q;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    pwm_channel #(
      .CNT_W       (CNT_W),
      .SYNC_STAGES (SYNC_STAGES),
      .ACTIVE_LOW  (ACTIVE_LOW)
    ) u_ch (
      .clk        (clk),
      .reset_n    (reset_n),
      .en         (en),
      .sig        (sig_in[i]),
      .pop        (pop_c[i]),
      .hold_v     (hold_v[i]),
      .hold_width (hold_width[i]),
      .hold_flags (hold_flags[i])
    );
  end

  assign out_load_c = ~out_v_q | mif.m_ready;

  // Round-robin search starting just after the last granted channel.
  always_comb begin
    int unsigned idx;
    idx     = 0;
    gnt_v_c = 1'b0;
    gnt_c   = '0;
    for (int unsigned k = 1; k <= NUM_CH; k++) begin
      idx = (32'(ptr_q) + k) % NUM_CH;
      if (!gnt_v_c && hold_v[CH_W'(idx)]) begin
        gnt_v_c = 1'b1;
        gnt_c   = CH_W'(idx);
      end
    end
  end

  always_comb begin
    pop_c = '0;
    if (out_load_c && gnt_v_c) pop_c[gnt_c] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q   <= CH_W'(NUM_CH - 1);
      out_v_q <= 1'b0;
      ch_q    <= '0;
      width_q <= '0;
      flags_q <= '0;
    end else if (out_load_c) begin
      out_v_q <= gnt_v_c;
      if (gnt_v_c) begin
        ptr_q   <= gnt_c;
        ch_q    <= gnt_c;
        width_q <= hold_width[gnt_c];
        flags_q <= hold_flags[gnt_c];
      end
    end
  end

  assign mif.m_valid = out_v_q;
  assign mif.m_ch    = ch_q;
  assign mif.m_width = width_q;
  assign mif.m_sat   = flags_q.sat;
  assign mif.m_lost  = flags_q.lost;

endmodule

// File: tb/tb_multi_pulse_width_meter.sv
// Directed bench: dut_a is active-high with a 4-bit counter, dut_b is active-low with 16 bits.
module tb_multi_pulse_width_meter;

  typedef struct {
    int unsigned ch;
    int unsigned width;
    int unsigned sat;
    int unsigned lost;
    int unsigned cyc;
  } rec_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        en_a, en_b;
  logic [3:0]  sig_a, sig_b;
  int unsigned cyc = 0;
  int          errs = 0;
  int          n_chk = 0;
  rec_t        q_a[$];
  rec_t        q_b[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  multi_pulse_width_meter_if #(.NUM_CH(4), .CNT_W(4))  mif_a ();
  multi_pulse_width_meter_if #(.NUM_CH(4), .CNT_W(16)) mif_b ();

  multi_pulse_width_meter #(.NUM_CH(4), .CNT_W(4), .SYNC_STAGES(2), .ACTIVE_LOW(0)) dut_a (
    .clk(clk), .reset_n(reset_n), .en(en_a), .sig_in(sig_a), .mif(mif_a.master));

  multi_pulse_width_meter #(.NUM_CH(4), .CNT_W(16), .SYNC_STAGES(2), .ACTIVE_LOW(1)) dut_b (
    .clk(clk), .reset_n(reset_n), .en(en_b), .sig_in(sig_b), .mif(mif_b.master));

  // Log every handshake; inputs only change just after posedge, so negedge sees the transfer.
  always @(negedge clk) begin
    if (reset_n && mif_a.m_valid && mif_a.m_ready)
      q_a.push_back('{ch: 32'(mif_a.m_ch), width: 32'(mif_a.m_width),
                      sat: 32'(mif_a.m_sat), lost: 32'(mif_a.m_lost), cyc: cyc});
    if (reset_n && mif_b.m_valid && mif_b.m_ready)
      q_b.push_back('{ch: 32'(mif_b.m_ch), width: 32'(mif_b.m_width),
                      sat: 32'(mif_b.m_sat), lost: 32'(mif_b.m_lost), cyc: cyc});
  end

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_chk++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_res(input bit use_b, input string tag, input int unsigned ch,
                            input int unsigned w, input int unsigned sat,
                            input int unsigned lost, output int unsigned at);
    rec_t r;
    int   k;
    int   sz;
    k  = 0;
    sz = use_b ? q_b.size() : q_a.size();
    while (sz == 0 && k < 80) begin
      tick(1);
      k++;
      sz = use_b ? q_b.size() : q_a.size();
    end
    at = 0;
    if (sz == 0) begin
      check({tag, "_timeout"}, 0, 1);
    end else begin
      if (use_b) r = q_b.pop_front();
      else       r = q_a.pop_front();
      check({tag, "_ch"},    r.ch,    ch);
      check({tag, "_width"}, r.width, w);
      check({tag, "_sat"},   r.sat,   sat);
      check({tag, "_lost"},  r.lost,  lost);
      at = r.cyc;
    end
  endtask

  task automatic expect_none(input bit use_b, input string tag, input int n);
    tick(n);
    check(tag, use_b ? q_b.size() : q_a.size(), 0);
  endtask

  task automatic pulse_a(input int ch, input int w);
    sig_a[ch] = 1'b1;
    tick(w);
    sig_a[ch] = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int unsigned t0, at0, at1, at2;
    reset_n = 1'b0;
    en_a = 1'b0;
    en_b = 1'b0;
    sig_a = 4'h0;
    sig_b = 4'hF;
    mif_a.m_ready = 1'b0;
    mif_b.m_ready = 1'b0;
    tick(3);

    check("rst_valid_a", 32'(mif_a.m_valid), 0);
    check("rst_ch_a",    32'(mif_a.m_ch),    0);
    check("rst_width_a", 32'(mif_a.m_width), 0);
    check("rst_sat_a",   32'(mif_a.m_sat),   0);
    check("rst_lost_a",  32'(mif_a.m_lost),  0);
    check("rst_valid_b", 32'(mif_b.m_valid), 0);
    check("rst_width_b", 32'(mif_b.m_width), 0);

    reset_n = 1'b1;
    tick(2);
    en_a = 1'b1;
    mif_a.m_ready = 1'b1;
    mif_b.m_ready = 1'b1;

    // ch0 and ch1 pending together straight after reset: ch0 wins
    sig_a = 4'b0011;
    tick(2);
    sig_a = 4'b0000;
    expect_res(0, "prio_first", 0, 2, 0, 0, at0);
    expect_res(0, "prio_second", 1, 2, 0, 0, at1);

    // basic width and pin-to-valid latency
    tick(3);
    pulse_a(0, 5);
    t0 = cyc;
    expect_res(0, "w5", 0, 5, 0, 0, at0);
    check("w5_latency", at0 - t0, 4);
    tick(3);
    pulse_a(0, 1);
    expect_res(0, "w1", 0, 1, 0, 0, at0);

    // saturation then recovery
    tick(3);
    pulse_a(2, 20);
    expect_res(0, "sat20", 2, 15, 1, 0, at0);
    tick(3);
    pulse_a(2, 3);
    expect_res(0, "after_sat", 2, 3, 0, 0, at0);

    // backpressure: 3 parks in the output, 6 overwrites 4 in the holding register
    tick(3);
    mif_a.m_ready = 1'b0;
    pulse_a(1, 3);
    tick(3);
    pulse_a(1, 4);
    tick(3);
    pulse_a(1, 6);
    tick(8);
    check("bp_valid", 32'(mif_a.m_valid), 1);
    check("bp_ch",    32'(mif_a.m_ch),    1);
    check("bp_width", 32'(mif_a.m_width), 3);
    check("bp_empty", q_a.size(), 0);
    tick(2);
    check("bp_stable_width", 32'(mif_a.m_width), 3);
    mif_a.m_ready = 1'b1;
    expect_res(0, "bp_w3", 1, 3, 0, 0, at0);
    expect_res(0, "bp_w6", 1, 6, 0, 1, at1);
    expect_none(0, "bp_no_w4", 10);

    // arbitration: park pointer on ch3, then simultaneous trails
    pulse_a(3, 2);
    expect_res(0, "arb_prep", 3, 2, 0, 0, at0);
    tick(3);
    sig_a = 4'b1011;
    tick(2);
    sig_a = 4'b0000;
    expect_res(0, "arb_0", 0, 2, 0, 0, at0);
    expect_res(0, "arb_1", 1, 2, 0, 0, at1);
    expect_res(0, "arb_3", 3, 2, 0, 0, at2);
    check("arb_b2b_01", at1 - at0, 1);
    check("arb_b2b_13", at2 - at1, 1);
    tick(3);
    sig_a = 4'b1001;
    tick(3);
    sig_a = 4'b0000;
    expect_res(0, "arb2_0", 0, 3, 0, 0, at0);
    expect_res(0, "arb2_3", 3, 3, 0, 0, at1);

    // active-low: enable rising mid-pulse must not arm
    sig_b[0] = 1'b0;
    tick(3);
    en_b = 1'b1;
    tick(4);
    sig_b[0] = 1'b1;
    expect_none(1, "en_rise_mid", 12);

    // enable falling mid-pulse discards it
    sig_b[1] = 1'b0;
    tick(4);
    en_b = 1'b0;
    tick(2);
    sig_b[1] = 1'b1;
    tick(4);
    en_b = 1'b1;
    expect_none(1, "en_fall_mid", 12);

    // full 7-cycle low pulse
    sig_b[2] = 1'b0;
    tick(7);
    sig_b[2] = 1'b1;
    t0 = cyc;
    expect_res(1, "low7", 2, 7, 0, 0, at0);
    check("low7_latency", at0 - t0, 4);

    tick(5);
    $display("Result: errors=%0d of %0d checks", errs, n_chk);
    $finish;
  end

endmodule
